// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Purpose  : Parametrised UART transmitter with valid/ready input, one-entry
//            holding buffer, runtime parity/stop selection. Optional line-break
//            generation when UART_TX_BREAK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(2 * CPB);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 parbit_q, parbit_d;
    logic                 stop2_q, stop2_d;

    logic                 buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
    logic [1:0]           buf_par_q, buf_par_d;
    logic                 buf_stop_q, buf_stop_d;

    logic w_break;
    logic w_accept;
    logic w_bit_last;
    logic w_load;

`ifdef UART_TX_BREAK_EN
    // Break only takes the line once the FSM is idle; a running frame finishes first.
    assign w_break = send_break && (state_q == ST_IDLE);
`else
    assign w_break = 1'b0;
`endif

    assign w_accept   = in_valid && !buf_full_q;
    assign w_bit_last = (state_q == ST_STOP && stop2_q) ? (cnt_q == STOP2_LAST)
                                                        : (cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        parbit_d   = parbit_q;
        stop2_d    = stop2_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_par_d  = buf_par_q;
        buf_stop_d = buf_stop_q;
        w_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (buf_full_q && !w_break) begin
                    w_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (w_bit_last) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_last) begin
                    cnt_d = '0;
                    if (buf_full_q) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (w_load) begin
            state_d    = ST_START;
            cnt_d      = '0;
            shift_d    = buf_data_q;
            par_en_d   = (buf_par_q == 2'd1) || (buf_par_q == 2'd2);
            parbit_d   = (^buf_data_q) ^ (buf_par_q == 2'd1);
            stop2_d    = buf_stop_q;
            buf_full_d = 1'b0;
        end

        // Accept needs an empty buffer before the edge, so it never collides with a load.
        if (w_accept) begin
            buf_full_d = 1'b1;
            buf_data_d = in_data;
            buf_par_d  = parity_mode;
            buf_stop_d = stop_bits;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            parbit_q   <= 1'b0;
            stop2_q    <= 1'b0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            buf_par_q  <= 2'd0;
            buf_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            parbit_q   <= parbit_d;
            stop2_q    <= stop2_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_par_q  <= buf_par_d;
            buf_stop_q <= buf_stop_d;
        end
    end

    always_comb begin
        serial_out = 1'b1;
        case (state_q)
            ST_IDLE:   serial_out = !w_break;
            ST_START:  serial_out = 1'b0;
            ST_DATA:   serial_out = shift_q[0];
            ST_PARITY: serial_out = parbit_q;
            ST_STOP:   serial_out = 1'b1;
            default:   serial_out = 1'b1;
        endcase
    end

    assign in_ready   = !buf_full_q;
    assign tx_busy    = (state_q != ST_IDLE) || w_break;
    assign frame_done = (state_q == ST_STOP) && w_bit_last;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_param
// Purpose  : Self-checking bench for uart_tx_param (8-bit and 7-bit instances)
//            against a cycle-by-cycle expected-line queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data0 = '0;
    logic [6:0] in_data1 = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [1:0] pm0 = '0, pm1 = '0;
    logic       sb0 = 1'b0, sb1 = 1'b0;
    logic       brk = 1'b0;
    logic       so0, so1, busy0, busy1, done0, done1, rdy0, rdy1;

    int vectors = 0;
    int miscompares = 0;

    // Expected entry per cycle: {ready_returns, frame_done, tx_busy, line}
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       mr0 = 1'b1, mr1 = 1'b1;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst_n),
        .in_data    (in_data0),
        .in_valid   (valid0),
        .in_ready   (rdy0),
        .parity_mode(pm0),
        .stop_bits  (sb0),
`ifdef UART_TX_BREAK_EN
        .send_break (brk),
`endif
        .serial_out (so0),
        .tx_busy    (busy0),
        .frame_done (done0)
    );

    uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7)) u_dut7 (
        .clk        (clk),
        .rst        (rst_n),
        .in_data    (in_data1),
        .in_valid   (valid1),
        .in_ready   (rdy1),
        .parity_mode(pm1),
        .stop_bits  (sb1),
`ifdef UART_TX_BREAK_EN
        .send_break (1'b0),
`endif
        .serial_out (so1),
        .tx_busy    (busy1),
        .frame_done (done1)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Expand one frame into per-clock line values from the framing rules.
    task automatic push_frame(input int id, input logic [7:0] d, input logic [1:0] pm,
                              input logic sb);
        logic [3:0] f[$];
        int nb;
        int ones;
        int nstop;
        logic p;
        nb    = (id == 0) ? 8 : 7;
        ones  = 0;
        nstop = sb ? 2 * CPB : CPB;
        if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0))
            f.push_back(4'b0001);
        for (int c = 0; c < CPB; c++) f.push_back({(c == 0), 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < nb; i++) begin
            ones += int'(d[i]);
            for (int c = 0; c < CPB; c++) f.push_back({3'b001, d[i]});
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            p = ((ones % 2) == 1) ^ (pm == 2'd1);
            for (int c = 0; c < CPB; c++) f.push_back({3'b001, p});
        end
        for (int c = 0; c < nstop; c++) f.push_back({1'b0, (c == nstop - 1), 1'b1, 1'b1});
        foreach (f[k]) begin
            if (id == 0) q0.push_back(f[k]);
            else         q1.push_back(f[k]);
        end
    endtask

    task automatic tick(output logic a0, output logic a1);
        logic [3:0] e0, e1;
        a0 = valid0 && mr0;
        a1 = valid1 && mr1;
        @(posedge clk);
        if (a0) begin push_frame(0, in_data0, pm0, sb0); mr0 = 1'b0; end
        if (a1) begin push_frame(1, {1'b0, in_data1}, pm1, sb1); mr1 = 1'b0; end
        e0 = (q0.size() != 0) ? q0.pop_front() : (brk ? 4'b0010 : 4'b0001);
        e1 = (q1.size() != 0) ? q1.pop_front() : 4'b0001;
        if (e0[3]) mr0 = 1'b1;
        if (e1[3]) mr1 = 1'b1;
        #1;
        vectors++;
        check("line8",  so0,   e0[0]);
        check("busy8",  busy0, e0[1]);
        check("done8",  done0, e0[2]);
        check("ready8", rdy0,  mr0);
        check("line7",  so1,   e1[0]);
        check("busy7",  busy1, e1[1]);
        check("done7",  done1, e1[2]);
        check("ready7", rdy1,  mr1);
    endtask

    task automatic idle(input int n);
        logic a0, a1;
        repeat (n) tick(a0, a1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !mr0 || !mr1) && k < 5000) begin
            idle(1);
            k++;
        end
        idle(3);
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic [1:0] pm,
                        input logic sb);
        logic a0, a1;
        logic got;
        int n;
        got = 1'b0;
        n   = 0;
        if (id == 0) begin in_data0 = d; pm0 = pm; sb0 = sb; valid0 = 1'b1; end
        else begin in_data1 = d[6:0]; pm1 = pm; sb1 = sb; valid1 = 1'b1; end
        while (!got && n < 2000) begin
            tick(a0, a1);
            got = (id == 0) ? a0 : a1;
            n++;
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        // Scramble inputs after acceptance; the queued frame must be unaffected.
        in_data0 = 8'($urandom);
        in_data1 = 7'($urandom);
        pm0 = 2'($urandom); pm1 = 2'($urandom);
        sb0 = 1'($urandom); sb1 = 1'($urandom);
        assert (got) else begin
            miscompares++;
            $error("FAIL accept_timeout id=%0d: observed no handshake expected handshake", id);
        end
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(2);

        send(0, 8'h55, 2'd0, 1'b0);
        drain();
        send(0, 8'h07, 2'd1, 1'b0);
        drain();
        send(0, 8'h07, 2'd2, 1'b0);
        drain();
        send(0, 8'hA3, 2'd0, 1'b1);
        drain();
        send(0, 8'hA3, 2'd3, 1'b0);
        drain();

        send(0, 8'h12, 2'd0, 1'b0);
        idle(20);
        send(0, 8'h34, 2'd0, 1'b0);
        drain();

        send(1, 8'h7F, 2'd2, 1'b0);
        drain();

        send(0, 8'h5A, 2'd1, 1'b1);
        idle(35);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        mr0 = 1'b1;
        mr1 = 1'b1;
        #1;
        check("rst_line", so0, 1'b1);
        check("rst_ready", rdy0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        idle(4);
        rst_n = 1'b1;
        idle(2);
        send(0, 8'hC3, 2'd2, 1'b0);
        drain();

`ifdef UART_TX_BREAK_EN
        brk = 1'b1;
        idle(50);
        brk = 1'b0;
        idle(5);
`endif

        for (int i = 0; i < 24; i++) begin
            send(int'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 150)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
